rs_cmd_sequencer: RTL and testbench

Controller that shares a single RS flip-flop between two requesters (A and B). It arbitrates set/reset commands round-robin and drives the flop's S and R inputs as timed, mutually exclusive pulses with a guard gap after each. It keeps a shadow of the flop's state, so commands that would not change the state complete without a pulse. It sits between control logic and the RS storage element, so S=R=1 can never reach the flop.

---
 rtl/rs_cmd_sequencer_if.sv | 25 ++
 rtl/rs_cmd_sequencer.sv | 137 +++++++++++++
 tb/tb_rs_cmd_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_cmd_sequencer_if.sv
// Request/ack handshake for two requesters plus the S/R drive and shadow status of the
// shared RS flop.
interface rs_cmd_sequencer_if;
    logic req_a;
    logic cmd_a;
    logic ack_a;
    logic req_b;
    logic cmd_b;
    logic ack_b;
    logic s_out;
    logic r_out;
    logic q_shadow;
    logic shadow_valid;
    logic busy;

    modport master (
        output req_a, cmd_a, req_b, cmd_b,
        input  ack_a, ack_b, s_out, r_out, q_shadow, shadow_valid, busy
    );

    modport slave (
        input  req_a, cmd_a, req_b, cmd_b,
        output ack_a, ack_b, s_out, r_out, q_shadow, shadow_valid, busy
    );
endinterface

// File: rtl/rs_cmd_sequencer.sv
// Round-robin set/reset sequencer for one shared RS flop: timed, mutually exclusive S/R
// pulses with a guard gap, and a shadow that turns no-op commands into immediate acks.
module rs_cmd_sequencer #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GUARD_W = 1,
    parameter int unsigned CNT_W   = 4
) (
    input logic               clk,
    input logic               rst,
    rs_cmd_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GuardLoad = (GUARD_W == 0) ? '0 : CNT_W'(GUARD_W - 1);
    localparam bit               HasGuard  = (GUARD_W != 0);

    typedef enum logic [1:0] {StIdle, StPulse, StGuard, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             grant_b_q;
    logic             cmd_q;
    logic             last_b_q;
    logic             s_q;
    logic             r_q;
    logic             ack_a_q;
    logic             ack_b_q;
    logic             shadow_q;
    logic             valid_q;
    logic             busy_q;

    logic any_req;
    logic pick_b;
    logic pick_cmd;
    logic redundant;

    // B wins only when A is absent or A was served last.
    always_comb begin
        any_req   = bus.req_a | bus.req_b;
        pick_b    = bus.req_b & (~bus.req_a | ~last_b_q);
        pick_cmd  = pick_b ? bus.cmd_b : bus.cmd_a;
        redundant = valid_q & (pick_cmd == shadow_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            grant_b_q <= 1'b0;
            cmd_q     <= 1'b0;
            last_b_q  <= 1'b1;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            shadow_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_b_q <= pick_b;
                        cmd_q     <= pick_cmd;
                        last_b_q  <= pick_b;
                        busy_q    <= 1'b1;
                        if (redundant) begin
                            state_q <= StDone;
                            ack_a_q <= ~pick_b;
                            ack_b_q <= pick_b;
                        end else begin
                            state_q <= StPulse;
                            cnt_q   <= PulseLoad;
                            s_q     <= pick_cmd;
                            r_q     <= ~pick_cmd;
                        end
                    end
                end
                StPulse: begin
                    if (cnt_q == '0) begin
                        s_q      <= 1'b0;
                        r_q      <= 1'b0;
                        shadow_q <= cmd_q;
                        valid_q  <= 1'b1;
                        if (HasGuard) begin
                            state_q <= StGuard;
                            cnt_q   <= GuardLoad;
                        end else begin
                            state_q <= StDone;
                            ack_a_q <= ~grant_b_q;
                            ack_b_q <= grant_b_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StGuard: begin
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                        ack_a_q <= ~grant_b_q;
                        ack_b_q <= grant_b_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_out        = s_q;
    assign bus.r_out        = r_q;
    assign bus.ack_a        = ack_a_q;
    assign bus.ack_b        = ack_b_q;
    assign bus.q_shadow     = shadow_q;
    assign bus.shadow_valid = valid_q;
    assign bus.busy         = busy_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(s_q && r_q));
            assert (!(ack_a_q && ack_b_q));
        end
    end
`endif

endmodule

// File: tb/tb_rs_cmd_sequencer.sv
// Self-checking bench: directed scenarios on two parameterisations plus a randomized run
// against a transaction-level timing model of the sequencer.
module tb_rs_cmd_sequencer;

    localparam int P = 2;
    localparam int G = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rs_cmd_sequencer_if bus ();
    rs_cmd_sequencer_if bus0 ();

    rs_cmd_sequencer #(.PULSE_W(P), .GUARD_W(G), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rs_cmd_sequencer #(.PULSE_W(1), .GUARD_W(0), .CNT_W(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        bus.req_a = 0; bus.cmd_a = 0; bus.req_b = 0; bus.cmd_b = 0;
        bus0.req_a = 0; bus0.cmd_a = 0; bus0.req_b = 0; bus0.cmd_b = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.s_out, bus.r_out, bus.ack_a, bus.ack_b, bus.q_shadow, bus.shadow_valid,
             bus.busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_main: got s,r,ackA,ackB,q,v,busy=%b%b%b%b%b%b%b want 0000000",
                     bus.s_out, bus.r_out, bus.ack_a, bus.ack_b, bus.q_shadow,
                     bus.shadow_valid, bus.busy);
        end
        n_checks++;
        if ({bus0.s_out, bus0.r_out, bus0.ack_a, bus0.ack_b, bus0.q_shadow,
             bus0.shadow_valid, bus0.busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_g0: outputs not all zero after reset");
        end
        rst = 0;
    endtask

    task automatic test_set_pulse();
        logic exp_s, exp_ack, exp_busy;
        bus.cmd_a = 1; bus.req_a = 1;
        for (int k = 1; k <= P + G + 2; k++) begin
            @(negedge clk);
            exp_s    = (k <= P);
            exp_ack  = (k == P + G + 1);
            exp_busy = (k <= P + G + 1);
            n_checks++;
            if ({bus.s_out, bus.r_out, bus.ack_a, bus.ack_b, bus.busy} !==
                {exp_s, 1'b0, exp_ack, 1'b0, exp_busy}) begin
                n_fail++;
                $display("FAIL set_pulse edge %0d: got s,r,ackA,ackB,busy=%b%b%b%b%b want %b0%b0%b",
                         k, bus.s_out, bus.r_out, bus.ack_a, bus.ack_b, bus.busy,
                         exp_s, exp_ack, exp_busy);
            end
            if (bus.ack_a) bus.req_a = 0;
        end
        bus.req_a = 0;
        n_checks++;
        if ({bus.q_shadow, bus.shadow_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL set_pulse shadow: got q,v=%b%b want 11", bus.q_shadow,
                     bus.shadow_valid);
        end
    endtask

    task automatic test_redundant();
        bus.cmd_b = 1; bus.req_b = 1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.s_out, bus.r_out, bus.ack_a, bus.ack_b, bus.busy} !==
                {1'b0, 1'b0, 1'b0, (k == 1), (k == 1)}) begin
                n_fail++;
                $display("FAIL redundant edge %0d: got s,r,ackA,ackB,busy=%b%b%b%b%b", k,
                         bus.s_out, bus.r_out, bus.ack_a, bus.ack_b, bus.busy);
            end
            if (bus.ack_b) bus.req_b = 0;
        end
        bus.req_b = 0;
        n_checks++;
        if (bus.q_shadow !== 1'b1) begin
            n_fail++;
            $display("FAIL redundant shadow: got %b want 1", bus.q_shadow);
        end
    endtask

    task automatic test_round_robin();
        int acks = 0;
        int last = 1;
        int who;
        int s_cnt = 0;
        int r_cnt = 0;
        bit rearm_a = 0;
        bit rearm_b = 0;
        bus.cmd_a = 0; bus.req_a = 1;
        bus.cmd_b = 1; bus.req_b = 1;
        for (int c = 0; c < 100 && acks < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.s_out && bus.r_out) begin
                n_fail++;
                $display("FAIL rr s_r_exclusive: both high at cycle %0d", c);
            end
            s_cnt += int'(bus.s_out);
            r_cnt += int'(bus.r_out);
            if (bus.ack_a || bus.ack_b) begin
                who = bus.ack_b ? 1 : 0;
                n_checks++;
                if (who != 1 - last) begin
                    n_fail++;
                    $display("FAIL rr order ack %0d: got requester %0d want %0d", acks, who,
                             1 - last);
                end
                n_checks++;
                if (bus.q_shadow !== who[0]) begin
                    n_fail++;
                    $display("FAIL rr shadow ack %0d: got %b want %b", acks, bus.q_shadow,
                             who[0]);
                end
                n_checks++;
                if ((who == 1 && (s_cnt != P || r_cnt != 0)) ||
                    (who == 0 && (r_cnt != P || s_cnt != 0))) begin
                    n_fail++;
                    $display("FAIL rr pulse ack %0d: got s_cycles=%0d r_cycles=%0d want %0d",
                             acks, s_cnt, r_cnt, P);
                end
                s_cnt = 0; r_cnt = 0;
                last  = who;
                acks++;
                if (who == 0) begin bus.req_a = 0; rearm_a = 1; end
                else          begin bus.req_b = 0; rearm_b = 1; end
            end else begin
                if (rearm_a) begin bus.req_a = 1; rearm_a = 0; end
                if (rearm_b) begin bus.req_b = 1; rearm_b = 0; end
            end
            if (acks == 4) begin bus.req_a = 0; bus.req_b = 0; end
        end
        bus.req_a = 0; bus.req_b = 0;
        n_checks++;
        if (acks != 4) begin
            n_fail++;
            $display("FAIL rr timeout: got %0d acks want 4", acks);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.q_shadow} !== 2'b01) begin
            n_fail++;
            $display("FAIL rr final: got busy,q=%b%b want 01", bus.busy, bus.q_shadow);
        end
    endtask

    task automatic test_guard_zero();
        bus0.cmd_a = 0; bus0.req_a = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus0.s_out, bus0.r_out, bus0.ack_a, bus0.ack_b, bus0.busy} !==
                {1'b0, (k == 1), (k == 2), 1'b0, (k <= 2)}) begin
                n_fail++;
                $display("FAIL guard_zero edge %0d: got s,r,ackA,ackB,busy=%b%b%b%b%b", k,
                         bus0.s_out, bus0.r_out, bus0.ack_a, bus0.ack_b, bus0.busy);
            end
            if (bus0.ack_a) bus0.req_a = 0;
        end
        bus0.req_a = 0;
        n_checks++;
        if ({bus0.q_shadow, bus0.shadow_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL guard_zero shadow: got q,v=%b%b want 01", bus0.q_shadow,
                     bus0.shadow_valid);
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit got_ack = 0;
        bus.cmd_a = 0; bus.req_a = 1;
        for (int c = 0; c < 20 && !got_ack; c++) begin
            @(negedge clk);
            if (bus.ack_a) begin got_ack = 1; bus.req_a = 0; end
        end
        bus.req_a = 0;
        n_checks++;
        if (!got_ack) begin
            n_fail++;
            $display("FAIL mid_reset prep: got no ack_a want ack within 20 cycles");
        end
        @(negedge clk);
        n_checks++;
        if ({bus.q_shadow, bus.shadow_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_reset prep shadow: got q,v=%b%b want 01", bus.q_shadow,
                     bus.shadow_valid);
        end
        bus.cmd_a = 1; bus.req_a = 1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.s_out, bus.r_out} !== 2'b10) begin
                n_fail++;
                $display("FAIL mid_reset pulse edge %0d: got s,r=%b%b want 10", k, bus.s_out,
                         bus.r_out);
            end
        end
        rst = 1;
        @(negedge clk);
        n_checks++;
        if ({bus.s_out, bus.r_out, bus.q_shadow, bus.shadow_valid, bus.busy, bus.ack_a,
             bus.ack_b} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset after: got s,r,q,v,busy,ackA,ackB=%b%b%b%b%b%b%b want 0",
                     bus.s_out, bus.r_out, bus.q_shadow, bus.shadow_valid, bus.busy,
                     bus.ack_a, bus.ack_b);
        end
        rst = 0; bus.req_a = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.ack_a, bus.ack_b, bus.busy} !== 3'b0) begin
                n_fail++;
                $display("FAIL mid_reset no_ack cycle %0d: got ackA,ackB,busy=%b%b%b want 000",
                         k, bus.ack_a, bus.ack_b, bus.busy);
            end
        end
    endtask

    // Transaction-level model: a grant at edge n acks at n+1 (no-op) or n+P+G+1, and the
    // sequencer can next sample requests one edge after the ack.
    task automatic test_random();
        bit pend[2] = '{0, 0};
        bit pcmd[2] = '{0, 0};
        bit out = 0;
        bit redund = 0;
        bit rcmd = 0;
        bit m_valid = 0;
        bit m_shadow = 0;
        int m_last = 1;
        int who = 0;
        int g_at = 0;
        int a_at = 0;
        int next_sample = 0;
        int grants = 0;
        int acks = 0;
        bit acked[2];
        logic e_s, e_r, e_aa, e_ab, e_busy, pul;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            pul    = out && !redund && n >= g_at + 1 && n <= g_at + P;
            e_s    = pul && rcmd;
            e_r    = pul && !rcmd;
            e_aa   = out && n == a_at && who == 0;
            e_ab   = out && n == a_at && who == 1;
            e_busy = out && n >= g_at + 1 && n <= a_at;
            n_checks++;
            if ({bus.s_out, bus.r_out, bus.ack_a, bus.ack_b, bus.busy} !==
                {e_s, e_r, e_aa, e_ab, e_busy}) begin
                n_fail++;
                $display("FAIL random cycle %0d: got s,r,ackA,ackB,busy=%b%b%b%b%b want %b%b%b%b%b",
                         n, bus.s_out, bus.r_out, bus.ack_a, bus.ack_b, bus.busy,
                         e_s, e_r, e_aa, e_ab, e_busy);
            end
            n_checks++;
            if ((bus.s_out && bus.r_out) || (bus.ack_a && bus.ack_b)) begin
                n_fail++;
                $display("FAIL random exclusive cycle %0d: got s,r=%b%b ackA,ackB=%b%b", n,
                         bus.s_out, bus.r_out, bus.ack_a, bus.ack_b);
            end
            acked = '{0, 0};
            if (bus.ack_a || bus.ack_b) acks++;
            if (out && n == a_at) begin
                n_checks++;
                if ({bus.q_shadow, bus.shadow_valid} !== {m_shadow, m_valid}) begin
                    n_fail++;
                    $display("FAIL random shadow cycle %0d: got q,v=%b%b want %b%b", n,
                             bus.q_shadow, bus.shadow_valid, m_shadow, m_valid);
                end
                pend[who]  = 0;
                acked[who] = 1;
                out        = 0;
            end
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && !acked[r] && n < 1000 && $urandom_range(0, 3) == 0) begin
                    pend[r] = 1;
                    pcmd[r] = 1'($urandom_range(0, 1));
                end
            end
            bus.req_a = pend[0]; bus.cmd_a = pcmd[0];
            bus.req_b = pend[1]; bus.cmd_b = pcmd[1];
            if (!out && n >= next_sample && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) who = 1 - m_last;
                else                    who = pend[1] ? 1 : 0;
                rcmd        = pcmd[who];
                redund      = m_valid && (rcmd == m_shadow);
                g_at        = n;
                a_at        = n + (redund ? 1 : P + G + 1);
                next_sample = a_at + 1;
                m_last      = who;
                m_shadow    = rcmd;
                m_valid     = 1;
                out         = 1;
                grants++;
            end
        end
        n_checks++;
        if (pend[0] || pend[1] || out || grants != acks) begin
            n_fail++;
            $display("FAIL random drain: got grants=%0d acks=%0d pendA=%b pendB=%b", grants,
                     acks, pend[0], pend[1]);
        end
        bus.req_a = 0; bus.req_b = 0;
    endtask

    initial begin
        test_reset();
        test_set_pulse();
        test_redundant();
        test_round_robin();
        test_guard_zero();
        test_reset_mid_pulse();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
